// File: rtl/clk_div_gen.sv
// clk_div_gen: multi-channel divided-clock generator with a lock sequencer.
// Each channel produces a registered square wave with period div (high for
// floor(div/2) cycles). All channels start together after a settle interval.
// A valid/ready port reconfigures one channel at a time.
//
// Ports:
//   clk_in1    in   reference clock
//   reset      in   asynchronous, active-high reset
//   cfg_valid  in   reconfiguration request
//   cfg_ready  out  request can be accepted (high whenever reset is low)
//   cfg_chan   in   target channel index
//   cfg_div    in   new divide ratio (values below 2 are stored as 2)
//   cfg_phase  in   new start count (values >= divide are stored as 0)
//   clk_out    out  generated clocks, bit i = channel i
//   locked     out  all channels running with the current configuration
module clk_div_gen #(
  parameter  int unsigned NUM_CH      = 5,
  parameter  int unsigned DIV_W       = 8,
  parameter  int unsigned LOCK_CYCLES = 64,
  parameter  int unsigned DEF_DIV     = 2,
  localparam int unsigned CHW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in1,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CHW-1:0]    cfg_chan,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  output logic [NUM_CH-1:0] clk_out,
  output logic              locked
);

  localparam int unsigned LCW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic {
    WAIT_LOCK = 1'b0,
    RUN       = 1'b1
  } state_e;

  state_e                         state_q, state_d;
  logic [LCW-1:0]                 lock_cnt_q, lock_cnt_d;
  logic [NUM_CH-1:0][DIV_W-1:0]   div_q, div_d;
  logic [NUM_CH-1:0][DIV_W-1:0]   phase_q, phase_d;
  logic [NUM_CH-1:0][DIV_W-1:0]   cnt_q, cnt_d;
  logic [NUM_CH-1:0]              clk_out_q, clk_out_d;
  logic                           locked_q, locked_d;

  logic [DIV_W-1:0] div_cl;
  logic [DIV_W-1:0] phase_cl;
  logic             cfg_hit;

  // The port is ready in every operating state; only reset blocks it.
  assign cfg_ready = ~reset;

  // Clamp the request and qualify it; out-of-range channels complete the
  // handshake but have no effect.
  always_comb begin
    div_cl   = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
    phase_cl = (cfg_phase >= div_cl) ? '0 : cfg_phase;
    cfg_hit  = cfg_valid && cfg_ready && (32'(cfg_chan) < NUM_CH);
  end

  // State and datapath registers.
  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      state_q    <= WAIT_LOCK;
      lock_cnt_q <= '0;
      div_q      <= {NUM_CH{DIV_W'(DEF_DIV)}};
      phase_q    <= '0;
      cnt_q      <= '0;
      clk_out_q  <= '0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      div_q      <= div_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      clk_out_q  <= clk_out_d;
      locked_q   <= locked_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    div_d      = div_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    clk_out_d  = clk_out_q;
    locked_d   = locked_q;

    unique case (state_q)
      WAIT_LOCK: begin
        lock_cnt_d = lock_cnt_q + LCW'(1);
        clk_out_d  = '0;
        locked_d   = 1'b0;
        if (lock_cnt_q == LCW'(LOCK_CYCLES - 1)) begin
          // Every channel is preloaded from its phase on the same edge.
          state_d  = RUN;
          locked_d = 1'b1;
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            cnt_d[i]     = phase_q[i];
            clk_out_d[i] = phase_q[i] < (div_q[i] >> 1);
          end
        end
      end
      RUN: begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          cnt_d[i]     = (cnt_q[i] == div_q[i] - DIV_W'(1)) ? '0 : cnt_q[i] + DIV_W'(1);
          clk_out_d[i] = cnt_d[i] < (div_q[i] >> 1);
        end
      end
      default: state_d = WAIT_LOCK;
    endcase

    // An accepted request overrides everything, including the final lock edge,
    // and re-locks all channels so they stay phase aligned.
    if (cfg_hit) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (CHW'(i) == cfg_chan) begin
          div_d[i]   = div_cl;
          phase_d[i] = phase_cl;
        end
      end
      state_d    = WAIT_LOCK;
      lock_cnt_d = '0;
      locked_d   = 1'b0;
      clk_out_d  = '0;
    end
  end

  assign clk_out = clk_out_q;
  assign locked  = locked_q;

endmodule

// File: doc/clk_div_gen.md
Name: clk_div_gen

Overview:
- Parametrised, synthesizable multi-channel clock generator driven from a single input clock.
- Each channel produces a registered clock-enable-style square wave at clk_in1/div with a programmable start phase.
- A lock sequencer holds all outputs low until a settle interval has elapsed, then asserts locked.
- Runtime reconfiguration per channel through a valid/ready port. Used as a simulation- and FPGA-portable substitute for a vendor clock wizard in capture-path testbenches and low-rate logic.

Parameters:
- NUM_CH, 5, number of output channels (1..16).
- DIV_W, 8, width of divide and phase fields.
- LOCK_CYCLES, 64, clk_in1 rising edges from reset release (or reconfig) to locked=1; must be >=1.
- DEF_DIV, 2, divide ratio loaded into every channel at reset (>=2).

Ports:
- clk_in1  in  1  reference clock.
- reset  in  1  reset, asynchronous, active-high.
- cfg_valid  in  1  reconfiguration request.
- cfg_ready  out  1  high when a request can be accepted.
- cfg_chan  in  $clog2(NUM_CH) (min 1)  target channel index.
- cfg_div  in  DIV_W  new divide ratio.
- cfg_phase  in  DIV_W  new start count (phase offset, in clk_in1 cycles).
- clk_out  out  NUM_CH  generated clocks, bit i = channel i.
- locked  out  1  all channels running with current configuration.

Behaviour:
- Reset (async, active-high): state=WAIT_LOCK; lock_cnt=0; every div_reg=DEF_DIV, phase_reg=0, cnt=0; clk_out=0; locked=0; cfg_ready=0 while reset is high.
- States:
  - WAIT_LOCK: lock_cnt increments each edge. clk_out held 0, locked=0, cfg_ready=1. On the edge where lock_cnt==LOCK_CYCLES-1, go to RUN; on that same edge locked<=1, cnt[i]<=phase_reg[i], clk_out[i]<=(phase_reg[i] < div_reg[i]>>1). Result: locked first reads 1 after the LOCK_CYCLES-th rising edge following reset release.
  - RUN: cnt[i] <= (cnt[i]==div_reg[i]-1) ? 0 : cnt[i]+1, and clk_out[i] <= (next cnt[i] < div_reg[i]>>1). Output is high for floor(div/2) cycles and low for ceil(div/2) cycles; period is div cycles. cfg_ready=1.
- Handshake: a request is accepted on an edge where cfg_valid && cfg_ready.
  - On accept, div_reg[cfg_chan] and phase_reg[cfg_chan] update, state<=WAIT_LOCK, lock_cnt<=0, locked<=0, and all clk_out<=0 on the same edge. All channels re-lock together so phase alignment is preserved.
  - Accept while in WAIT_LOCK restarts lock_cnt at 0.
- Clamping:
  - cfg_div<2 is stored as 2.
  - cfg_phase>=div (after clamp) is stored as 0.
  - cfg_chan>=NUM_CH: the request is accepted (handshake completes) but ignored, with no re-lock; state and locked are unchanged.
- Simultaneous events:
  - Reset dominates everything.
  - An accept on the final WAIT_LOCK edge wins: stay in WAIT_LOCK, lock_cnt<=0, locked stays 0.
- Reset mid-RUN: outputs drop asynchronously to 0 and configuration returns to DEF_DIV/phase 0.
- lock_cnt width is $clog2(LOCK_CYCLES+1); no wrap occurs before the transition.

Test Plan:
1. Defaults (clk_in1 period 20 ns), release reset at 1000 ns -> locked rises at the 64th rising edge after release; each clk_out bit toggles every edge, period 40 ns, all bits in phase; cfg_ready=1.
2. In RUN, send cfg_chan=1, cfg_div=5, cfg_phase=2 for one cycle -> on that edge locked=0 and all clk_out=0. locked returns 64 edges later. clk_out[1] per edge from re-lock (cnt 2,3,4,0,1,...) = 0,0,0,1,1, repeating with period 100 ns. The other channels resume /2, aligned.
3. cfg_div=1 and cfg_div=0 on channel 0 -> stored as 2, period 40 ns. cfg_phase=9 with cfg_div=4 -> phase stored as 0.
4. cfg_chan=7 (NUM_CH=5) -> cfg_ready handshake completes; locked stays 1; no clk_out disturbance.
5. Second request issued 30 cycles into WAIT_LOCK -> locked rises 64 edges after the second accept, not the first.
6. Assert reset for 3 ns mid-RUN between edges -> clk_out=0 and locked=0 immediately. After release, default configuration (all /2) and locked again after 64 edges.
